seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Run-control and configuration wrapper around a bit-serial pattern detector of the seq0110 family.
- Holds a programmable pattern, length, overlap mode and match target.
- Arms and disarms detection, counts matches, and signals completion.
- Out of reset it behaves as a 0110 detector with overlap, so it drops in where the fixed detector sits today.

Parameters:
- PAT_W, 4, maximum pattern length in bits.
- CNT_W, 8, match counter width.
- LEN_W, $clog2(PAT_W)+1, width of the length field (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_we  input  1  loads cfg_pattern/cfg_len/cfg_overlap/cfg_target; honoured only in IDLE or DONE.
- cfg_pattern  input  PAT_W  pattern; bit cfg_len-1 is the first bit received.
- cfg_len  input  LEN_W  pattern length 1..PAT_W; 0 or >PAT_W is treated as PAT_W.
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
- cfg_target  input  CNT_W  matches until DONE; 0 = free-run.
- start  input  1  arm detection; honoured only in IDLE or DONE.
- stop  input  1  abort to IDLE.
- in  input  1  serial data, sampled every rising edge while armed.
- seq_detected  output  1  one-cycle match pulse.
- match_count  output  CNT_W  matches since last start.
- busy  output  1  high in ARMED or RUN.
- done  output  1  high in DONE.
- state  output  2  IDLE=0, ARMED=1, RUN=2, DONE=3.

Behaviour:
- Reset (async, any time including mid-run):
  - state=IDLE; seq_detected=0; match_count=0; busy=0; done=0.
  - History and fill count cleared.
  - Config registers reset to pattern 0110, len 4, overlap 1, target 0.
- Config:
  - cfg_we in IDLE/DONE latches all four fields on the edge; ignored in ARMED/RUN.
  - If cfg_we and start occur on the same edge, the new config is used by that run.
- IDLE/DONE + start -> ARMED:
  - Clears history, fill count, match_count and seq_detected.
  - done drops on that edge.
- ARMED (fill):
  - Each edge shifts in into history (new bit at LSB) and increments the fill count.
  - When the fill count reaches len, go to RUN.
- Match rule:
  - On an edge where the low len bits of {history, in} equal the low len bits of the pattern, and at least len valid bits exist including the current one, a match occurs.
  - This includes the edge that completes the fill.
- Match latency:
  - seq_detected is registered: high for exactly one cycle after the edge that sampled the last pattern bit.
  - match_count updates on that same edge.
- Overlap handling:
  - overlap=1: history retained; stay in or enter RUN.
  - overlap=0: fill count cleared and state returns to ARMED, so the next match needs len fresh bits.
- Counting:
  - match_count saturates at 2^CNT_W-1 and never wraps.
  - In free-run (target 0) the pulses continue after saturation.
- Target:
  - If target!=0 and a match brings match_count to target, go to DONE on that edge.
  - The final seq_detected pulse is still issued; done=1 and busy=0 from the next cycle.
  - No sampling occurs in DONE.
- Stop:
  - stop in ARMED/RUN -> IDLE on the next edge.
  - A match on the stop edge is discarded: no pulse, no count.
  - match_count is held for readback; busy=0.
  - stop in IDLE/DONE is ignored.
  - stop and start on the same edge: stop wins if busy; start wins if not busy.
- start while busy is ignored; it never restarts a run.
- len=1: every edge where in==pattern[0] is a match, with no fill delay beyond the first bit.

Test Plan:
- Reset defaults, start, drive in = 0,1,0,0,1,1,0 -> one seq_detected pulse, the cycle after the final 0; match_count=1; state=RUN.
- Default config, start, drive 0110110 with overlap=1 -> 2 pulses, count=2; same stream with overlap=0 -> 1 pulse, count=1.
- cfg pattern=101, len=3, target=2; start; drive 1,0,1,0,1 -> pulses after bits 3 and 5; done=1, busy=0, state=DONE; further input produces no pulse.
- Free-run with CNT_W=2, 5 matches -> match_count sticks at 3; 5 pulses seen.
- stop asserted on the edge completing 0110 -> no pulse, count unchanged, state=IDLE next cycle; cfg_we during RUN -> config unchanged.
- rst asserted asynchronously mid-RUN (between edges) -> all outputs 0 immediately; config back to 0110/4/1/0.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-control and configuration wrapper around a bit-serial
// pattern detector. Holds a programmable pattern, length, overlap mode and
// match target. Arms and disarms detection, counts matches and flags
// completion. Out of reset it behaves as a 0110 detector with overlap.
module seq_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             stop,
  input  logic             in,
  output logic             seq_detected,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [PAT_W-1:0] hist_reg, hist_next;
  logic [LEN_W-1:0] fill_reg, fill_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             det_reg, det_next;

  // Configuration registers; length is stored already sanitised to 1..PAT_W.
  logic [PAT_W-1:0] pat_reg, pat_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             ovl_reg, ovl_next;
  logic [CNT_W-1:0] tgt_reg, tgt_next;

  logic [LEN_W-1:0] cfg_len_eff;
  logic [PAT_W-1:0] len_mask;
  logic [PAT_W:0]   win_full;
  logic [PAT_W-1:0] window;
  logic [LEN_W:0]   fill_inc;
  logic             fill_full;
  logic             hit;
  logic [CNT_W-1:0] count_inc;
  logic             cfg_open;

  // Out-of-range lengths fall back to the full pattern width.
  assign cfg_len_eff = ((cfg_len == '0) || (cfg_len > LEN_W'(PAT_W))) ? LEN_W'(PAT_W) : cfg_len;

  // Mask selecting the low len_reg bits of the compare window.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign len_mask[gi] = (LEN_W'(gi) < len_reg);
  end

  // Window includes the bit being sampled this edge (new bit at LSB).
  assign win_full  = {hist_reg, in};
  assign window    = win_full[PAT_W-1:0];
  assign fill_inc  = {1'b0, fill_reg} + 1'b1;
  assign fill_full = (fill_inc >= {1'b0, len_reg});
  assign hit       = fill_full && (((window ^ pat_reg) & len_mask) == '0);
  assign count_inc = (count_reg == '1) ? count_reg : count_reg + 1'b1;
  assign cfg_open  = (state_reg == IDLE) || (state_reg == DONE);

  // State and datapath registers with asynchronous reset to the 0110 defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      hist_reg  <= '0;
      fill_reg  <= '0;
      count_reg <= '0;
      det_reg   <= 1'b0;
      pat_reg   <= PAT_W'(4'b0110);
      len_reg   <= LEN_W'(4);
      ovl_reg   <= 1'b1;
      tgt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      count_reg <= count_next;
      det_reg   <= det_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      ovl_reg   <= ovl_next;
      tgt_reg   <= tgt_next;
    end
  end

  // Next-state, detection and configuration logic.
  always_comb begin
    state_next = state_reg;
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    count_next = count_reg;
    det_next   = 1'b0;
    pat_next   = pat_reg;
    len_next   = len_reg;
    ovl_next   = ovl_reg;
    tgt_next   = tgt_reg;

    // Config writes only land while no run is in progress; a write on the
    // start edge is therefore in place for the first sampled bit.
    if (cfg_we && cfg_open) begin
      pat_next = cfg_pattern;
      len_next = cfg_len_eff;
      ovl_next = cfg_overlap;
      tgt_next = cfg_target;
    end

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = ARMED;
          hist_next  = '0;
          fill_next  = '0;
          count_next = '0;
        end
      end
      ARMED, RUN: begin
        if (stop) begin
          // Any match on this edge is dropped; count is held for readback.
          state_next = IDLE;
        end else begin
          hist_next = window;
          if (hit) begin
            det_next   = 1'b1;
            count_next = count_inc;
            if ((tgt_reg != '0) && (count_inc == tgt_reg)) begin
              state_next = DONE;
              fill_next  = len_reg;
            end else if (ovl_reg) begin
              state_next = RUN;
              fill_next  = len_reg;
            end else begin
              // Non-overlapping: the next match needs len fresh bits.
              state_next = ARMED;
              fill_next  = '0;
            end
          end else begin
            fill_next  = fill_full ? len_reg : fill_inc[LEN_W-1:0];
            state_next = fill_full ? RUN : ARMED;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign seq_detected = det_reg;
  assign match_count  = count_reg;
  assign busy         = (state_reg == ARMED) || (state_reg == RUN);
  assign done         = (state_reg == DONE);
  assign state        = state_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl, built with a 2-bit match counter
// so saturation is reachable quickly. Expected pulse/count per sampled bit is
// pushed to a scoreboard queue as each bit is driven, and popped after the edge.
module tb_seq_detect_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             in = 1'b0;
  logic             seq_detected;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  typedef struct {
    logic             det;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .stop(stop), .in(in), .seq_detected(seq_detected),
    .match_count(match_count), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one serial bit, queue its expected outcome, check after the edge.
  task automatic drive(input logic b, input logic ed, input logic [CNT_W-1:0] ec, input string nm);
    exp_t e;
    in = b;
    sb.push_back('{ed, ec, nm});
    @(posedge clk); #1;
    e = sb.pop_front();
    n_cmp++;
    if (seq_detected !== e.det) begin
      n_err++;
      $display("FAIL %s det: got %b expected %b", e.name, seq_detected, e.det);
    end
    n_cmp++;
    if (match_count !== e.cnt) begin
      n_err++;
      $display("FAIL %s count: got %0d expected %0d", e.name, match_count, e.cnt);
    end
    $display("bit %b -> det=%b count=%0d state=%0d (%s)", b, seq_detected, match_count, state, e.name);
  endtask

  task automatic check_state(input logic [1:0] es, input string nm);
    n_cmp++;
    if (state !== es) begin
      n_err++;
      $display("FAIL %s state: got %0d expected %0d", nm, state, es);
    end
  endtask

  task automatic do_cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                        input logic o, input logic [CNT_W-1:0] t, input logic with_start);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
    cfg_we = 1'b1; start = with_start;
    @(posedge clk); #1;
    cfg_we = 1'b0; start = 1'b0;
    $display("cfg pat=%b len=%0d ovl=%b tgt=%0d start=%b", p, l, o, t, with_start);
  endtask

  task automatic do_start(input string nm);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_state(2'd1, nm);
    n_cmp++;
    if (match_count !== '0 || seq_detected !== 1'b0) begin
      n_err++;
      $display("FAIL %s clear: got count=%0d det=%b expected 0/0", nm, match_count, seq_detected);
    end
    $display("start -> state=%0d count=%0d (%s)", state, match_count, nm);
  endtask

  task automatic do_stop(input string nm);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check_state(2'd0, nm);
    $display("stop -> state=%0d busy=%b (%s)", state, busy, nm);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({seq_detected, match_count, busy, done, state} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got det=%b cnt=%0d busy=%b done=%b state=%0d expected all 0",
               seq_detected, match_count, busy, done, state);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check_state(2'd0, "reset_idle");
    $display("reset released -> state=%0d", state);
  endtask

  task automatic test_basic();
    do_start("basic_start");
    drive(0, 0, 0, "basic_b1");
    drive(1, 0, 0, "basic_b2");
    drive(0, 0, 0, "basic_b3");
    drive(0, 0, 0, "basic_b4");
    drive(1, 0, 0, "basic_b5");
    drive(1, 0, 0, "basic_b6");
    drive(0, 1, 1, "basic_b7");
    check_state(2'd2, "basic_run");
    do_stop("basic_stop");
  endtask

  task automatic test_overlap();
    do_start("ovl1_start");
    drive(0, 0, 0, "ovl1_b1");
    drive(1, 0, 0, "ovl1_b2");
    drive(1, 0, 0, "ovl1_b3");
    drive(0, 1, 1, "ovl1_b4");
    drive(1, 0, 1, "ovl1_b5");
    drive(1, 0, 1, "ovl1_b6");
    drive(0, 1, 2, "ovl1_b7");
    do_stop("ovl1_stop");
    do_cfg(4'b0110, 3'd4, 1'b0, 2'd0, 1'b0);
    do_start("ovl0_start");
    drive(0, 0, 0, "ovl0_b1");
    drive(1, 0, 0, "ovl0_b2");
    drive(1, 0, 0, "ovl0_b3");
    drive(0, 1, 1, "ovl0_b4");
    drive(1, 0, 1, "ovl0_b5");
    drive(1, 0, 1, "ovl0_b6");
    drive(0, 0, 1, "ovl0_b7");
    check_state(2'd1, "ovl0_armed");
    do_stop("ovl0_stop");
  endtask

  task automatic test_target();
    // Config written on the same edge as start must apply to this run.
    do_cfg(4'b0101, 3'd3, 1'b1, 2'd2, 1'b1);
    check_state(2'd1, "tgt_armed");
    drive(1, 0, 0, "tgt_b1");
    drive(0, 0, 0, "tgt_b2");
    drive(1, 1, 1, "tgt_b3");
    drive(0, 0, 1, "tgt_b4");
    drive(1, 1, 2, "tgt_b5");
    check_state(2'd3, "tgt_done");
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL tgt_flags: got done=%b busy=%b expected 1/0", done, busy);
    end
    drive(0, 0, 2, "tgt_idle_b6");
    drive(1, 0, 2, "tgt_idle_b7");
    stop = 1'b1;
    drive(0, 0, 2, "tgt_stop_in_done");
    stop = 1'b0;
    check_state(2'd3, "tgt_stop_ignored");
  endtask

  task automatic test_saturate();
    do_cfg(4'b0001, 3'd1, 1'b1, 2'd0, 1'b0);
    do_start("sat_start");
    drive(1, 1, 1, "sat_m1");
    drive(1, 1, 2, "sat_m2");
    drive(0, 0, 2, "sat_gap");
    drive(1, 1, 3, "sat_m3");
    drive(1, 1, 3, "sat_m4");
    // start while busy must not restart the run.
    start = 1'b1;
    drive(1, 1, 3, "sat_m5_start_busy");
    start = 1'b0;
    check_state(2'd2, "sat_run");
    do_stop("sat_stop");
  endtask

  task automatic test_len_zero();
    do_cfg(4'b0110, 3'd0, 1'b1, 2'd0, 1'b1);
    drive(0, 0, 0, "len0_b1");
    drive(1, 0, 0, "len0_b2");
    drive(1, 0, 0, "len0_b3");
    drive(0, 1, 1, "len0_b4");
    do_stop("len0_stop");
  endtask

  task automatic test_stop_and_cfg_lock();
    do_cfg(4'b0110, 3'd4, 1'b1, 2'd0, 1'b0);
    do_start("stopm_start");
    drive(0, 0, 0, "stopm_b1");
    drive(1, 0, 0, "stopm_b2");
    drive(1, 0, 0, "stopm_b3");
    stop = 1'b1;
    drive(0, 0, 0, "stopm_b4_stop");
    stop = 1'b0;
    check_state(2'd0, "stopm_idle");
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL stopm_busy: got %b expected 0", busy);
    end
    do_start("lock_start");
    drive(0, 0, 0, "lock_b1");
    drive(1, 0, 0, "lock_b2");
    drive(1, 0, 0, "lock_b3");
    drive(0, 1, 1, "lock_b4");
    cfg_pattern = 4'b1111; cfg_len = 3'd1; cfg_overlap = 1'b0; cfg_target = 2'd1;
    cfg_we = 1'b1;
    drive(1, 0, 1, "lock_b5");
    drive(1, 0, 1, "lock_b6");
    drive(0, 1, 2, "lock_b7");
    cfg_we = 1'b0;
    check_state(2'd2, "lock_run");
  endtask

  task automatic test_async_reset();
    // Enter the cycle with seq_detected high so an immediate drop is visible.
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({seq_detected, match_count, busy, done, state} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got det=%b cnt=%0d busy=%b done=%b state=%0d expected all 0",
               seq_detected, match_count, busy, done, state);
    end
    $display("async reset mid-run -> det=%b count=%0d state=%0d", seq_detected, match_count, state);
    #1 rst = 1'b0;
    do_start("post_rst_start");
    drive(0, 0, 0, "post_rst_b1");
    drive(1, 0, 0, "post_rst_b2");
    drive(1, 0, 0, "post_rst_b3");
    drive(0, 1, 1, "post_rst_b4");
    drive(1, 0, 1, "post_rst_b5");
    drive(1, 0, 1, "post_rst_b6");
    drive(0, 1, 2, "post_rst_b7");
    check_state(2'd2, "post_rst_run");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_target();
    test_saturate();
    test_len_zero();
    test_stop_and_cfg_lock();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
